// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch sequencer
package cpu_pkg;

   localparam int INSTR_W      = 16;
   localparam int ADDR_W_DEF   = 16;
   localparam int RESET_PC_DEF = 0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      EXEC,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with branch load and wrapping increment
module pc_reg #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_target,
   input  logic              inc,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc
);

   // A branch load takes precedence; increment wraps naturally at 2^ADDR_W
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else if (ld_target) begin
         pc <= target;
      end else if (inc) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch FSM feeding the instruction register (optional FETCH_TIMEOUT_EN)
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF),
   parameter int                TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               mem_ack,
   output logic               ir_ld,
   output logic [INSTR_W-1:0] ir_data,
   input  logic               exec_done,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_target,
   input  logic               halt,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               halted,
   output logic               fetch_err
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic              pc_inc;
   logic              pc_ld;
   logic              timeout_hit;

   // PC advances on the accepted fetch, and reloads only on a taken, non-halting branch
   assign pc_inc = (state == FETCH) && mem_ack;
   assign pc_ld  = (state == EXEC) && exec_done && !halt && br_taken;
   assign pc_out = pc;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk       (clk),
      .reset     (reset),
      .ld_target (pc_ld),
      .inc       (pc_inc),
      .target    (br_target),
      .pc        (pc)
   );

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

   logic [7:0] tcnt;

   // A same-cycle ack always beats the timeout
   assign timeout_hit = (state == FETCH) && !mem_ack && (tcnt == TIMEOUT_LAST);

   // Counter is held at zero outside FETCH so each fetch starts fresh; error is sticky
   always_ff @(posedge clk) begin
      if (!reset) begin
         tcnt      <= '0;
         fetch_err <= 1'b0;
      end else begin
         if (state != FETCH) begin
            tcnt <= '0;
         end else if (!mem_ack) begin
            tcnt <= tcnt + 8'd1;
         end
         if (timeout_hit) begin
            fetch_err <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign fetch_err   = 1'b0;
`endif

   // Main sequencer: all handshake and IR outputs are registered here
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         ir_ld    <= 1'b0;
         ir_data  <= '0;
         halted   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state    <= FETCH;
                  mem_req  <= 1'b1;
                  mem_addr <= pc;
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  ir_data <= mem_rdata;
                  ir_ld   <= 1'b1;
                  mem_req <= 1'b0;
                  state   <= LOAD;
               end else if (timeout_hit) begin
                  mem_req <= 1'b0;
                  halted  <= 1'b1;
                  state   <= HALT;
               end
            end
            LOAD: begin
               ir_ld <= 1'b0;
               state <= EXEC;
            end
            EXEC: begin
               if (exec_done) begin
                  if (halt) begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end else if (run) begin
                     state    <= FETCH;
                     mem_req  <= 1'b1;
                     mem_addr <= br_taken ? br_target : pc;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            HALT: begin
               halted  <= 1'b1;
               mem_req <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

   localparam int TB_TIMEOUT = `ifdef FETCH_TIMEOUT_EN 4 `else 255 `endif ;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        ir_ld;
   logic [15:0] ir_data;
   logic        exec_done;
   logic        br_taken;
   logic [15:0] br_target;
   logic        halt;
   logic [15:0] pc_out;
   logic        halted;
   logic        fetch_err;

   int n_cmp    = 0;
   int n_bad    = 0;
   int ld_count = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .ADDR_W      (16),
      .RESET_PC    (16'h0000),
      .TIMEOUT_CYC (TB_TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .ir_ld     (ir_ld),
      .ir_data   (ir_data),
      .exec_done (exec_done),
      .br_taken  (br_taken),
      .br_target (br_target),
      .halt      (halt),
      .pc_out    (pc_out),
      .halted    (halted),
      .fetch_err (fetch_err)
   );

   always @(negedge clk) begin
      if (ir_ld === 1'b1) ld_count++;
   end

   task automatic do_fetch(input logic [15:0] addr, input logic [15:0] data, input int delay, input string tag);
      int i;
      i = 0;
      while (mem_req !== 1'b1 && i < 20) begin
         @(negedge clk);
         i++;
      end
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL %s req_wait: mem_req=%b required 1 within 20 cycles", tag, mem_req);
         return;
      end
      n_cmp++;
      if (mem_addr !== addr) begin
         n_bad++;
         $display("FAIL %s mem_addr: got %h required %h", tag, mem_addr, addr);
      end
      for (int d = 0; d < delay; d++) begin
         @(negedge clk);
         n_cmp++;
         if (mem_req !== 1'b1 || mem_addr !== addr) begin
            n_bad++;
            $display("FAIL %s req_hold: mem_req=%b mem_addr=%h required 1/%h", tag, mem_req, mem_addr, addr);
         end
      end
      mem_ack   = 1'b1;
      mem_rdata = data;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      n_cmp++;
      if (ir_ld !== 1'b1 || ir_data !== data || mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL %s load: ir_ld=%b ir_data=%h mem_req=%b required 1/%h/0", tag, ir_ld, ir_data, mem_req, data);
      end
      @(negedge clk);
      n_cmp++;
      if (ir_ld !== 1'b0 || ir_data !== data) begin
         n_bad++;
         $display("FAIL %s ld_pulse: ir_ld=%b ir_data=%h required 0/%h", tag, ir_ld, ir_data, data);
      end
   endtask

   task automatic do_exec(input int wait_cyc, input logic br, input logic [15:0] tgt, input logic hlt, input logic run_v);
      repeat (wait_cyc) @(negedge clk);
      run       = run_v;
      exec_done = 1'b1;
      br_taken  = br;
      br_target = tgt;
      halt      = hlt;
      @(negedge clk);
      exec_done = 1'b0;
      br_taken  = 1'b0;
      br_target = 16'h0000;
      halt      = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || ir_ld !== 1'b0 || halted !== 1'b0 || fetch_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_strobes: req/ld/halted/err=%b%b%b%b required 0000", mem_req, ir_ld, halted, fetch_err);
      end
      n_cmp++;
      if (mem_addr !== 16'h0000 || ir_data !== 16'h0000 || pc_out !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_values: mem_addr=%h ir_data=%h pc_out=%h required 0000/0000/0000", mem_addr, ir_data, pc_out);
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_no_run: mem_req=%b required 0", mem_req);
      end
   endtask

   task automatic test_first_fetch();
      run = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL run_latency: mem_req=%b required 1", mem_req);
      end
      do_fetch(16'h0000, 16'hA5C3, 1, "first");
      n_cmp++;
      if (pc_out !== 16'h0001) begin
         n_bad++;
         $display("FAIL first_pc: pc_out=%h required 0001", pc_out);
      end
   endtask

   task automatic test_sequential();
      do_exec(1, 1'b0, 16'h0, 1'b0, 1'b1);
      do_fetch(16'h0001, 16'h1234, 1, "seq1");
      do_exec(1, 1'b0, 16'h0, 1'b0, 1'b1);
      do_fetch(16'h0002, 16'h5678, 0, "seq2");
      n_cmp++;
      if (pc_out !== 16'h0003 || ld_count !== 3) begin
         n_bad++;
         $display("FAIL seq_end: pc_out=%h ld_count=%0d required 0003/3", pc_out, ld_count);
      end
   endtask

   task automatic test_branch();
      do_exec(0, 1'b1, 16'h0040, 1'b0, 1'b1);
      do_fetch(16'h0040, 16'hBEEF, 2, "branch");
      n_cmp++;
      if (pc_out !== 16'h0041) begin
         n_bad++;
         $display("FAIL branch_pc: pc_out=%h required 0041", pc_out);
      end
   endtask

   task automatic test_wrap();
      do_exec(0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
      do_fetch(16'hFFFF, 16'h0F0F, 1, "wrap_top");
      n_cmp++;
      if (pc_out !== 16'h0000) begin
         n_bad++;
         $display("FAIL wrap_pc: pc_out=%h required 0000", pc_out);
      end
      do_exec(0, 1'b0, 16'h0, 1'b0, 1'b1);
      do_fetch(16'h0000, 16'hC0DE, 1, "wrap_next");
   endtask

   task automatic test_idle_and_ignored();
      do_exec(0, 1'b0, 16'h0, 1'b0, 1'b0);
      mem_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (mem_req !== 1'b0 || ir_ld !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_quiet: mem_req=%b ir_ld=%b required 0/0", mem_req, ir_ld);
         end
         @(negedge clk);
         mem_ack = 1'b0;
      end
      run = 1'b1;
      @(negedge clk);
      do_fetch(16'h0001, 16'h3C3C, 1, "resume");
      mem_ack   = 1'b1;
      br_taken  = 1'b1;
      br_target = 16'h1234;
      halt      = 1'b1;
      @(negedge clk);
      mem_ack   = 1'b0;
      br_taken  = 1'b0;
      br_target = 16'h0000;
      halt      = 1'b0;
      n_cmp++;
      if (ir_ld !== 1'b0 || halted !== 1'b0 || pc_out !== 16'h0002 || mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL ignored_inputs: ir_ld=%b halted=%b pc_out=%h mem_req=%b required 0/0/0002/0", ir_ld, halted, pc_out, mem_req);
      end
      do_exec(0, 1'b0, 16'h0, 1'b0, 1'b1);
      do_fetch(16'h0002, 16'h4B4B, 0, "after_ignore");
   endtask

   task automatic test_halt();
      do_exec(0, 1'b1, 16'h0077, 1'b1, 1'b1);
      n_cmp++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || pc_out !== 16'h0003) begin
         n_bad++;
         $display("FAIL halt_entry: halted=%b mem_req=%b pc_out=%h required 1/0/0003", halted, mem_req, pc_out);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (halted !== 1'b1 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_hold: halted=%b mem_req=%b required 1/0", halted, mem_req);
         end
      end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run   = 1'b0;
      n_cmp++;
      if (halted !== 1'b0 || pc_out !== 16'h0000 || mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_reset: halted=%b pc_out=%h mem_req=%b required 0/0000/0", halted, pc_out, mem_req);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_fetch();
      run = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
         n_bad++;
         $display("FAIL midf_req: mem_req=%b mem_addr=%h required 1/0000", mem_req, mem_addr);
      end
      reset = 1'b0;
      run   = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL midf_drop: mem_req=%b required 0", mem_req);
      end
      mem_ack   = 1'b1;
      mem_rdata = 16'h9999;
      @(negedge clk);
      mem_ack   = 1'b0;
      n_cmp++;
      if (ir_ld !== 1'b0 || ir_data !== 16'h0000 || pc_out !== 16'h0000) begin
         n_bad++;
         $display("FAIL late_ack: ir_ld=%b ir_data=%h pc_out=%h required 0/0000/0000", ir_ld, ir_data, pc_out);
      end
      @(negedge clk);
      n_cmp++;
      if (ir_ld !== 1'b0) begin
         n_bad++;
         $display("FAIL late_ack_hold: ir_ld=%b required 0", ir_ld);
      end
   endtask

   task automatic test_timeout();
      run = 1'b1;
      @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
      repeat (3) @(negedge clk);
      n_cmp++;
      if (fetch_err !== 1'b0 || halted !== 1'b0 || mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL tmo_early: fetch_err=%b halted=%b mem_req=%b required 0/0/1", fetch_err, halted, mem_req);
      end
      @(negedge clk);
      n_cmp++;
      if (fetch_err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL tmo_fire: fetch_err=%b halted=%b mem_req=%b required 1/1/0", fetch_err, halted, mem_req);
      end
`else
      repeat (300) @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b1 || fetch_err !== 1'b0 || halted !== 1'b0) begin
         n_bad++;
         $display("FAIL long_wait: mem_req=%b fetch_err=%b halted=%b required 1/0/0", mem_req, fetch_err, halted);
      end
      do_fetch(16'h0000, 16'h7E57, 0, "long_wait");
`endif
   endtask

   initial begin
      reset     = 1'b0;
      run       = 1'b0;
      mem_rdata = 16'h0000;
      mem_ack   = 1'b0;
      exec_done = 1'b0;
      br_taken  = 1'b0;
      br_target = 16'h0000;
      halt      = 1'b0;
      @(negedge clk);
      test_reset();
      test_first_fetch();
      test_sequential();
      test_branch();
      test_wrap();
      test_idle_and_ignored();
      test_halt();
      test_reset_mid_fetch();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch stage that sits directly upstream of the 16-bit instruction register. It owns the program counter and issues word reads to external instruction memory over a req/ack handshake. It presents each fetched word on ir_data with a one-cycle ir_ld strobe, which drives the instruction register's ld/D_in. It then waits for the control unit to report execution complete before fetching again, taking branch redirects and halt into account.

Parameters:
ADDR_W, 16, program counter / memory address width in bits
RESET_PC, 0, PC value loaded on reset (ADDR_W bits)
TIMEOUT_CYC, 255, max FETCH cycles without mem_ack before error (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
run  in  1  start/continue fetching; level-sensitive
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  memory read address (= pc while mem_req=1)
mem_rdata  in  16  memory read data, valid when mem_ack=1
mem_ack  in  1  memory read complete, single-cycle pulse
ir_ld  out  1  one-cycle load strobe to instruction register
ir_data  out  16  fetched instruction word to instruction register D_in
exec_done  in  1  control unit finished executing the current instruction
br_taken  in  1  branch taken; qualified by exec_done
br_target  in  ADDR_W  branch destination; qualified by exec_done & br_taken
halt  in  1  stop fetching; qualified by exec_done
pc_out  out  ADDR_W  current program counter
halted  out  1  high while in HALT
fetch_err  out  1  sticky fetch-timeout flag (tied 0 without FETCH_TIMEOUT_EN)

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0, ir_ld=0, ir_data=16'h0000, halted=0, fetch_err=0, timeout counter=0.
- Reset overrides all other inputs, including mid-handshake. An outstanding ack is dropped; memory must tolerate an abandoned request.
- States: IDLE, FETCH, LOAD, EXEC, HALT.
- IDLE: all strobes low. run=1 -> FETCH on next edge.
- FETCH:
  - mem_req=1 and mem_addr=pc, both held stable until mem_ack.
  - On mem_ack: ir_data<=mem_rdata; pc<=pc+1 modulo 2^ADDR_W (all-ones wraps to 0); -> LOAD.
- LOAD: ir_ld=1 for exactly one cycle with ir_data stable; mem_req=0; -> EXEC unconditionally.
- EXEC: waits for exec_done. On exec_done, in priority order:
  1. halt=1 -> HALT (br_taken ignored).
  2. br_taken=1 -> pc<=br_target; then FETCH if run=1, else IDLE.
  3. Otherwise -> FETCH if run=1, else IDLE (pc keeps its incremented value).
- HALT: halted=1, mem_req=0; exits only via reset.
- Ignored inputs:
  - mem_ack outside FETCH.
  - br_taken, br_target and halt without exec_done.
  - run deassertion while in FETCH: the request always completes.
- Latency:
  - run sampled 1 in IDLE at edge N -> mem_req=1 during cycle N+1.
  - mem_ack at edge M -> ir_ld=1 during cycle M+1.
  - exec_done at edge K -> next mem_req=1 during cycle K+1.
  - Minimum instruction period: 3 cycles (ack same cycle as request, exec_done first EXEC cycle).
- ir_data holds its value between loads; it is never cleared except by reset.

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on FETCH entry and increments each FETCH cycle without mem_ack.
  - When it reaches TIMEOUT_CYC: fetch_err<=1 (sticky until reset), mem_req drops, -> HALT.
  - mem_ack on that same cycle wins: normal capture, no error.
- Not defined: no counter logic; fetch_err tied 0; FETCH waits indefinitely.

Decomposition:
- Shared package cpu_pkg:
  - state enum typedef fetch_state_t (IDLE, FETCH, LOAD, EXEC, HALT);
  - INSTR_W=16;
  - default ADDR_W and RESET_PC constants.
- One natural sub-module: pc_reg. Holds a load/increment program counter with synchronous active-low reset, ld_target and inc controls, and mod-2^ADDR_W wrap.

Test Plan:
- Reset then run=1, memory acks 1 cycle after req with 16'hA5C3 at addr 0 -> mem_addr=0, ir_ld pulse one cycle with ir_data=16'hA5C3, pc_out=1.
- Three sequential instructions with exec_done 2 cycles after each ir_ld -> mem_addr sequence 0,1,2; exactly three ir_ld pulses; pc_out=3.
- exec_done with br_taken=1, br_target=16'h0040 -> next mem_addr=16'h0040; pc_out=16'h0041 after ack.
- pc=16'hFFFF fetch, then exec_done -> next mem_addr=16'h0000 (wrap).
- exec_done with halt=1 and br_taken=1 in the same cycle -> halted=1, mem_req stays 0 thereafter, pc unchanged; reset low for one edge -> IDLE, pc=RESET_PC, halted=0.
- FETCH_TIMEOUT_EN defined with TIMEOUT_CYC=4, no mem_ack -> fetch_err=1 and halted=1 after 4 FETCH cycles. Also: reset asserted mid-FETCH, then late mem_ack -> ignored, ir_ld stays 0.
